// File: rtl/masked_sbox_sequencer.sv
// Handshake, randomness and clock-gating sequencer sitting in front of a masked HPC2 S-box.
// Shares pass straight through registers; no share slices are ever combined here.
module masked_sbox_sequencer #(
    parameter int SHARES  = 4,
    parameter int FRESH_W = 102,
    parameter int LATENCY = 9,
    parameter int TIMEOUT = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*SHARES-1:0]   in_x,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*SHARES-1:0]   out_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [126:0]          seed,
    input  logic                  seed_load,
    output logic [4*SHARES-1:0]   sbox_x,
    output logic [FRESH_W-1:0]    sbox_fresh,
    output logic                  sbox_start,
    input  logic [4*SHARES-1:0]   sbox_y,
    input  logic                  sbox_synch,
    output logic                  err
);
    localparam int LFSR_W  = 127;
    localparam int CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [4*SHARES-1:0] x_reg;
    logic [4*SHARES-1:0] y_reg;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   seed_fix;
    logic [LFSR_W-1:0]   lfsr_src;
    logic [LFSR_W-1:0]   lfsr_adv;

    // x^127 + x + 1 in Fibonacci form: shift toward the MSB, feedback from the two oldest bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < FRESH_W; i++)
            r = {r[LFSR_W-2:0], r[LFSR_W-1] ^ r[LFSR_W-2]};
        return r;
    endfunction

    always_comb begin
        seed_fix = (seed == '0) ? LFSR_ONE : seed;
        lfsr_src = ((state == S_IDLE) && seed_load) ? seed_fix : lfsr;
        lfsr_adv = lfsr_step(lfsr_src);
    end

    assign sbox_x     = x_reg;
    assign out_y      = y_reg;
    assign sbox_fresh = lfsr[FRESH_W-1:0];

    // The LFSR steps on every edge that leads into LAUNCH, WAIT or CAPT, so each of those
    // cycles presents a fresh word and IDLE/DONE hold the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            lfsr       <= LFSR_ONE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            sbox_start <= 1'b0;
            err        <= 1'b0;
        end else begin
            sbox_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    lfsr <= lfsr_src;
                    if (in_valid) begin
                        x_reg      <= in_x;
                        lfsr       <= lfsr_adv;
                        in_ready   <= 1'b0;
                        sbox_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    lfsr     <= lfsr_adv;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (sbox_synch) begin
                        lfsr  <= lfsr_adv;
                        state <= S_CAPT;
                    end else if (wait_cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        lfsr     <= lfsr_adv;
                    end
                end
                S_CAPT: begin
                    y_reg     <= sbox_y;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Directed + randomized bench for masked_sbox_sequencer with a behavioural S-box and LFSR bit-queue model.
module tb_masked_sbox_sequencer;
    localparam int SHARES  = 4;
    localparam int FRESH_W = 102;
    localparam int LATENCY = 9;
    localparam int TIMEOUT = 13;

    logic                clk = 1'b0;
    logic                rst;
    logic [4*SHARES-1:0] in_x;
    logic                in_valid;
    logic                in_ready;
    logic [4*SHARES-1:0] out_y;
    logic                out_valid;
    logic                out_ready;
    logic [126:0]        seed;
    logic                seed_load;
    logic [4*SHARES-1:0] sbox_x;
    logic [FRESH_W-1:0]  sbox_fresh;
    logic                sbox_start;
    logic [4*SHARES-1:0] sbox_y;
    logic                sbox_synch;
    logic                err;

    masked_sbox_sequencer #(
        .SHARES(SHARES), .FRESH_W(FRESH_W), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
        .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
        .seed(seed), .seed_load(seed_load),
        .sbox_x(sbox_x), .sbox_fresh(sbox_fresh), .sbox_start(sbox_start),
        .sbox_y(sbox_y), .sbox_synch(sbox_synch), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int starts = 0;
    bit exp_err = 1'b0;
    logic [15:0] exp_x = '0;
    logic [15:0] exp_y = '0;
    bit q[$];  // LFSR bit history, q[0] oldest, q[126] newest
    logic [3:0] s4 [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                            4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
        if (sbox_start) starts++;
    endtask

    task automatic mdl_load(input logic [126:0] s);
        logic [126:0] v;
        v = (s == '0) ? 127'h1 : s;
        q.delete();
        for (int i = 126; i >= 0; i--) q.push_back(v[i]);
    endtask

    task automatic mdl_adv();
        for (int i = 0; i < FRESH_W; i++) begin
            q.push_back(q[0] ^ q[1]);
            void'(q.pop_front());
        end
    endtask

    function automatic logic [FRESH_W-1:0] mdl_fresh();
        logic [FRESH_W-1:0] f;
        for (int i = 0; i < FRESH_W; i++) f[i] = q[126-i];
        return f;
    endfunction

    function automatic logic [3:0] unmask(input logic [15:0] s);
        return s[3:0] ^ s[7:4] ^ s[11:8] ^ s[15:12];
    endfunction

    // wait_n: WAIT cycle (0-based) in which synch fires, -1 = never; rst_at: WAIT cycle of mid-op reset.
    task automatic txn(input logic [15:0] x, input int wait_n, input int bp, input bit spur,
                       input bit seed_acc, input logic [126:0] sd, input int wload, input int rst_at);
        logic [15:0] y;
        logic [3:0]  r0, r1, r2;
        int st0, c0, bad;
        chk("idle_ready", 128'(in_ready), 128'(1));
        if (spur) begin
            sbox_synch = 1'b1;
            sbox_y = 16'($urandom);
            cyc();
            sbox_synch = 1'b0;
            chk("spur_idle_ready", 128'(in_ready), 128'(1));
            chk("spur_idle_valid", 128'(out_valid), 128'(0));
            chk("spur_idle_y", 128'(out_y), 128'(exp_y));
        end
        st0 = starts;
        in_x = x;
        in_valid = 1'b1;
        if (seed_acc) begin
            seed = sd;
            seed_load = 1'b1;
            mdl_load(sd);
        end
        cyc();
        c0 = cycle - 1;
        in_valid = 1'b0;
        seed_load = 1'b0;
        exp_x = x;
        mdl_adv();
        chk("launch_start", 128'(sbox_start), 128'(1));
        chk("launch_x", 128'(sbox_x), 128'(exp_x));
        chk("launch_ready", 128'(in_ready), 128'(0));
        chk("launch_fresh", 128'(sbox_fresh), 128'(mdl_fresh()));
        cyc();
        mdl_adv();
        for (int w = 0; w < TIMEOUT; w++) begin
            if (w == rst_at) begin
                rst = 1'b0;
                #1;
                exp_x = '0; exp_y = '0; exp_err = 1'b0;
                mdl_load('0);
                chk("mrst_ready", 128'(in_ready), 128'(1));
                chk("mrst_valid", 128'(out_valid), 128'(0));
                chk("mrst_start", 128'(sbox_start), 128'(0));
                chk("mrst_err", 128'(err), 128'(0));
                chk("mrst_x", 128'(sbox_x), 128'(0));
                chk("mrst_y", 128'(out_y), 128'(0));
                chk("mrst_fresh", 128'(sbox_fresh), 128'(1));
                #2 rst = 1'b1;
                in_valid = 1'b0;
                bad = 0;
                for (int k = 0; k < TIMEOUT + 4; k++) begin
                    cyc();
                    if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
                end
                chk("mrst_quiet", 128'(bad), 128'(0));
                return;
            end
            chk("wait_x", 128'(sbox_x), 128'(exp_x));
            chk("wait_ready", 128'(in_ready), 128'(0));
            chk("wait_fresh", 128'(sbox_fresh), 128'(mdl_fresh()));
            in_valid = spur;
            if (spur) in_x = ~x;
            seed_load = (w == wload);
            if (w == wload) seed = {$urandom, $urandom, $urandom, $urandom};
            if (w == wait_n) begin
                r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
                y = {r0 ^ r1 ^ r2 ^ s4[unmask(x)], r2, r1, r0};
                sbox_y = y;
                sbox_synch = 1'b1;
                cyc();
                sbox_synch = 1'b0;
                seed_load = 1'b0;
                in_valid = 1'b0;
                mdl_adv();
                chk("capt_valid", 128'(out_valid), 128'(0));
                chk("capt_x", 128'(sbox_x), 128'(exp_x));
                cyc();
                exp_y = y;
                sbox_y = 16'($urandom);
                chk("done_valid", 128'(out_valid), 128'(1));
                if (wait_n == LATENCY - 1)
                    chk("latency", 128'(cycle - c0), 128'(LATENCY + 3));
                chk("done_y", 128'(out_y), 128'(exp_y));
                chk("done_sbox", 128'(unmask(out_y)), 128'(s4[unmask(x)]));
                chk("done_fresh", 128'(sbox_fresh), 128'(mdl_fresh()));
                chk("start_pulses", 128'(starts - st0), 128'(1));
                for (int b = 0; b < bp; b++) begin
                    if (spur && b == 0) sbox_synch = 1'b1;
                    cyc();
                    sbox_synch = 1'b0;
                    chk("bp_ready", 128'(in_ready), 128'(0));
                    chk("bp_valid", 128'(out_valid), 128'(1));
                    chk("bp_y", 128'(out_y), 128'(exp_y));
                    chk("bp_fresh", 128'(sbox_fresh), 128'(mdl_fresh()));
                end
                out_ready = 1'b1;
                cyc();
                out_ready = 1'b0;
                chk("hs_valid", 128'(out_valid), 128'(0));
                chk("hs_ready", 128'(in_ready), 128'(1));
                chk("hs_y", 128'(out_y), 128'(exp_y));
                chk("hs_err", 128'(err), 128'(exp_err));
                return;
            end
            cyc();
            if (w == TIMEOUT - 1) begin
                seed_load = 1'b0;
                in_valid = 1'b0;
                exp_err = 1'b1;
                chk("to_err", 128'(err), 128'(1));
                chk("to_ready", 128'(in_ready), 128'(1));
                chk("to_valid", 128'(out_valid), 128'(0));
                chk("to_cycles", 128'(cycle - c0), 128'(TIMEOUT + 2));
                chk("to_fresh", 128'(sbox_fresh), 128'(mdl_fresh()));
                return;
            end
            mdl_adv();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_x = '0; in_valid = 1'b0; out_ready = 1'b0;
        seed = '0; seed_load = 1'b0;
        sbox_y = '0; sbox_synch = 1'b0;
        #2 rst = 1'b0;
        #9;
        mdl_load('0);
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_start", 128'(sbox_start), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_x", 128'(sbox_x), 128'(0));
        chk("rst_y", 128'(out_y), 128'(0));
        chk("rst_fresh", 128'(sbox_fresh), 128'(1));
        rst = 1'b1;
        cyc();

        txn(16'h5A3C, LATENCY - 1, 0, 1'b0, 1'b0, '0, -1, -1);
        txn(16'($urandom), LATENCY - 1, 20, 1'b0, 1'b0, '0, -1, -1);

        seed = {$urandom, $urandom, $urandom, $urandom};
        seed_load = 1'b1;
        cyc();
        mdl_load(seed);
        seed = '0;
        cyc();
        seed_load = 1'b0;
        mdl_load('0);
        chk("seed0_fresh", 128'(sbox_fresh), 128'(1));
        txn(16'($urandom), LATENCY - 1, 2, 1'b0, 1'b0, '0, 3, -1);
        txn(16'($urandom), LATENCY - 1, 1, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, -1);

        txn(16'($urandom), LATENCY - 1, 3, 1'b1, 1'b0, '0, -1, -1);

        for (int i = 0; i < 6; i++)
            txn(16'($urandom), int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, 3)),
                1'($urandom), 1'b0, '0, int'($urandom_range(0, 5)), -1);

        txn(16'($urandom), LATENCY - 1, 0, 1'b0, 1'b0, '0, -1, 4);
        txn(16'($urandom), LATENCY - 1, 1, 1'b0, 1'b0, '0, -1, -1);

        txn(16'($urandom), -1, 0, 1'b0, 1'b0, '0, -1, -1);
        txn(16'($urandom), LATENCY - 1, 2, 1'b0, 1'b0, '0, -1, -1);
        txn(16'($urandom), -1, 0, 1'b0, 1'b0, '0, -1, -1);
        txn(16'($urandom), TIMEOUT - 1, 1, 1'b0, 1'b0, '0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/masked_sbox_sequencer.md
# masked_sbox_sequencer

Control and randomness stage placed directly upstream of the clock-gated, order-3 HPC2 S-box (`Synch`-signalling, 9-cycle controller).
- Accepts one 4-bit, 4-share input nibble through a valid/ready handshake and holds the shares stable while the S-box computes.
- Starts the S-box's internal clock-gating controller and feeds it 102 fresh random bits every cycle from an internal LFSR.
- Captures the S-box's shared output after `Synch` and offers it downstream through a second valid/ready handshake.

## Interface
Parameters:
- `SHARES`, 4: share count (security order + 1); share i occupies bits [4i+3:4i] of every share bus.
- `FRESH_W`, 102: width of the fresh-randomness bus to the S-box.
- `LATENCY`, 9: nominal S-box cycles from start to `Synch`.
- `TIMEOUT`, 13: number of WAIT cycles without `Synch` before the error flag is raised.

Ports:
- `clk`, in, 1: single clock; the S-box shares this clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_x`, in, 4*SHARES: shared input nibble.
- `in_valid`, in, 1: input valid.
- `in_ready`, out, 1: input ready.
- `out_y`, out, 4*SHARES: shared output nibble.
- `out_valid`, out, 1: output valid.
- `out_ready`, in, 1: output ready.
- `seed`, in, 127: LFSR seed.
- `seed_load`, in, 1: load `seed` into the LFSR; honoured only in IDLE.
- `sbox_x`, out, 4*SHARES: shares driven to the S-box `X_s*` inputs.
- `sbox_fresh`, out, FRESH_W: drives the S-box `Fresh` input.
- `sbox_start`, out, 1: drives the S-box controller `rst` input; active-high, one-cycle pulse.
- `sbox_y`, in, 4*SHARES: S-box `Y_s*` outputs.
- `sbox_synch`, in, 1: S-box `Synch` output.
- `err`, out, 1: sticky timeout flag; cleared only by `rst`.

## Operation
States and transitions:
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch `in_x` into x_reg and go to LAUNCH.
- LAUNCH (1 cycle): `sbox_start`=1; clear the WAIT counter; go to WAIT.
- WAIT: counter increments every cycle.
  - `sbox_synch`=1: go to CAPT.
  - Counter reaches TIMEOUT-1 with no `sbox_synch`: set `err`, go to IDLE, no output produced.
- CAPT (1 cycle): y_reg <= `sbox_y`; go to DONE.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE.

Datapath rules:
- `sbox_x` is driven only from x_reg. It is constant from LAUNCH through CAPT and changes only on an accepted input.
- `out_y` is driven from y_reg. It is stable while `out_valid`=1 and holds its last value otherwise.
- The sequencer never combines shares; there is no XOR across share slices anywhere in this block.

LFSR:
- 127-bit Fibonacci LFSR, polynomial x^127 + x + 1.
- Advances exactly FRESH_W steps per cycle, unrolled, in LAUNCH, WAIT and CAPT. It holds in IDLE and DONE.
- `sbox_fresh` = state[FRESH_W-1:0].
- `seed_load` in IDLE loads `seed`; an all-zero seed loads 127'h1. `seed_load` in any other state is ignored.

Boundary conditions:
- `in_valid` outside IDLE: ignored; `in_ready`=0.
- `sbox_synch` outside WAIT: ignored.
- `seed_load` and an accepted input in the same IDLE cycle: both take effect; the new seed is used from LAUNCH.
- `err` set while already set: stays 1. Later transactions proceed normally.

## Timing
Reset values (asynchronous, `rst`=0):
- State = IDLE.
- `in_ready`=1; `out_valid`=0; `sbox_start`=0; `err`=0.
- x_reg=0; y_reg=0 (`out_y`=0).
- LFSR = 127'h1, so `sbox_fresh`=102'h1.
- Reset mid-transaction discards the transaction. `sbox_start` drops immediately.

Cycle-level latency:
- Input accepted in cycle 0.
- `sbox_start` high in cycle 1.
- With `sbox_synch` high in cycle t, CAPT is cycle t+1 and `out_valid` rises in cycle t+2.
- With a nominal S-box, `sbox_synch` occurs at t = 1+LATENCY. The total input-to-`out_valid` latency is therefore LATENCY+3 = 12 cycles.

Throughput and back-pressure:
- One nibble per transaction; no overlap.
- The earliest next acceptance is the cycle after the `out_valid`&`out_ready` handshake, since IDLE is re-entered then.
- `out_ready` held low keeps DONE indefinitely. The LFSR holds during this time.

## Test plan
- **Basic transaction.** Reset, then `in_x`=16'h5A3C with a real S-box attached.
  - `out_valid` rises 12 cycles after acceptance.
  - XOR of the `out_y` share slices equals SKINNY S4(XOR of the `in_x` slices).
  - `sbox_start` is exactly one pulse.
- **Back-pressure.** Hold `out_ready`=0 for 20 cycles after `out_valid`.
  - `out_y` is stable and `in_ready`=0 throughout.
  - `sbox_fresh` is unchanged during DONE.
  - The handshake completes in the first cycle `out_ready`=1.
- **Timeout.** Tie `sbox_synch`=0.
  - `err`=1 exactly 13 WAIT cycles after LAUNCH, and the state returns to IDLE.
  - A following transaction with a working S-box completes while `err` stays 1.
- **Seeding.** `seed_load` with `seed`=0.
  - The LFSR is 127'h1; the first LAUNCH `sbox_fresh` matches the reference model stepped 102 times.
  - `seed_load` during WAIT leaves the sequence unaltered.
- **Mid-operation reset.** Assert `rst`=0 in WAIT cycle 4.
  - All outputs are at their reset values in the same cycle; no `out_valid` appears.
  - The next transaction completes normally.
- **Spurious inputs.** Pulse `sbox_synch` in IDLE and DONE, and hold `in_valid` during WAIT.
  - No state change and no re-latch of x_reg or y_reg.
